// File: rtl/pwm_button_ctrl.sv
// pwm_button_ctrl
//   Input stage for the PWM duty-cycle generator. It synchronises and debounces
//   the raw increase and decrease push-buttons and issues single-cycle step
//   pulses. Pressing both buttons together issues no pulse.
//
//   Optional macro AUTO_REPEAT_EN: when it is defined, holding a button
//   auto-repeats its step pulse. The first repeat comes REPEAT_DELAY_TICKS
//   after the first pulse, and later repeats come every REPEAT_RATE_TICKS.
//   When it is undefined, each press gives exactly one pulse.
//
// Ports
//   clk        system clock, all logic on rising edge
//   rst        synchronous reset, active-high
//   btn_inc    raw asynchronous increase button, active-high
//   btn_dec    raw asynchronous decrease button, active-high
//   inc_pulse  one-clk step-up request
//   dec_pulse  one-clk step-down request
//   inc_level  debounced increase level
//   dec_level  debounced decrease level
module pwm_button_ctrl #(
    parameter int TICK_DIV           = 50000,
    parameter int DEBOUNCE_TICKS     = 8,
    parameter int REPEAT_DELAY_TICKS = 500,
    parameter int REPEAT_RATE_TICKS  = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_inc,
    input  logic btn_dec,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic inc_level,
    output logic dec_level
);

    localparam int TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW      = $clog2(DEBOUNCE_TICKS + 1);
    localparam int REP_MAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ?
                             REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
    localparam int RW      = $clog2(REP_MAX + 1);

    if (TICK_DIV < 1 || DEBOUNCE_TICKS < 1 ||
        REPEAT_DELAY_TICKS < 1 || REPEAT_RATE_TICKS < 1) begin : g_param_chk
        $error("pwm_button_ctrl: all parameters must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HOLD_INC = 3'd1,
        HOLD_DEC = 3'd2,
        REP_INC  = 3'd3,
        REP_DEC  = 3'd4,
        BOTH     = 3'd5
    } state_t;

    state_t state;

    // Index 0 is the increase button and index 1 is the decrease button.
    logic [1:0]         sync1, sync2, lvl;
    logic [1:0][DW-1:0] db_cnt;
    logic [TW-1:0]      tick_cnt;
    logic               tick;

    assign inc_level = lvl[0];
    assign dec_level = lvl[1];

    // Two-flop synchronisers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {btn_dec, btn_inc};
            sync2 <= sync1;
        end
    end

    // Debounce tick. When TICK_DIV is 1 the counter stays at 0, so tick is
    // high every cycle.
    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    // A changed level must persist for DEBOUNCE_TICKS consecutive ticks.
    // Any bounce back to the current level restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl    <= '0;
            db_cnt <= '0;
        end else if (tick) begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_TICKS - 1)) begin
                    lvl[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    logic [RW-1:0] rep_cnt;
    logic          hold_st, rep_st, rep_hit;

    // The counter runs only in HOLD and REP states and is held at 0 in IDLE
    // and BOTH. Every path into HOLD passes through IDLE, and HOLD to REP
    // wraps the counter at the pulse, so each new state starts from 0.
    assign hold_st = (state == HOLD_INC) || (state == HOLD_DEC);
    assign rep_st  = (state == REP_INC)  || (state == REP_DEC);
    assign rep_hit = tick && (hold_st ? (rep_cnt == RW'(REPEAT_DELAY_TICKS - 1))
                                      : (rep_cnt == RW'(REPEAT_RATE_TICKS - 1)));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            inc_pulse <= 1'b0;
            dec_pulse <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            inc_pulse <= 1'b0;
            dec_pulse <= 1'b0;
`ifdef AUTO_REPEAT_EN
            if (!(hold_st || rep_st)) rep_cnt <= '0;
            else if (rep_hit)         rep_cnt <= '0;
            else if (tick)            rep_cnt <= rep_cnt + 1'b1;
`endif
            case (state)
                IDLE: begin
                    if (inc_level && dec_level) begin
                        state <= BOTH;
                    end else if (inc_level) begin
                        inc_pulse <= 1'b1;
                        state     <= HOLD_INC;
                    end else if (dec_level) begin
                        dec_pulse <= 1'b1;
                        state     <= HOLD_DEC;
                    end
                end
`ifdef AUTO_REPEAT_EN
                HOLD_INC, REP_INC: begin
                    if (!inc_level)     state <= IDLE;
                    else if (dec_level) state <= BOTH;
                    else if (rep_hit) begin
                        inc_pulse <= 1'b1;
                        state     <= REP_INC;
                    end
                end
                HOLD_DEC, REP_DEC: begin
                    if (!dec_level)     state <= IDLE;
                    else if (inc_level) state <= BOTH;
                    else if (rep_hit) begin
                        dec_pulse <= 1'b1;
                        state     <= REP_DEC;
                    end
                end
`else
                HOLD_INC: begin
                    if (!inc_level)     state <= IDLE;
                    else if (dec_level) state <= BOTH;
                end
                HOLD_DEC: begin
                    if (!dec_level)     state <= IDLE;
                    else if (inc_level) state <= BOTH;
                end
`endif
                // Stay here until both buttons are released, so that
                // releasing only one of them cannot issue a pulse.
                BOTH: begin
                    if (!inc_level && !dec_level) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_button_ctrl.sv
// tb_pwm_button_ctrl
//   Directed bench for pwm_button_ctrl with TICK_DIV=2, DEBOUNCE_TICKS=3,
//   REPEAT_DELAY_TICKS=4 and REPEAT_RATE_TICKS=2.
module tb_pwm_button_ctrl;

    logic clk = 1'b0;
    logic rst, btn_inc, btn_dec;
    logic inc_pulse, dec_pulse, inc_level, dec_level;

    pwm_button_ctrl #(
        .TICK_DIV(2), .DEBOUNCE_TICKS(3),
        .REPEAT_DELAY_TICKS(4), .REPEAT_RATE_TICKS(2)
    ) dut (
        .clk(clk), .rst(rst), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
        .inc_level(inc_level), .dec_level(dec_level)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse monitor. It samples outputs 1 time unit after each rising edge.
    int cyc = 0, n_inc = 0, n_dec = 0, overlap = 0, wide = 0;
    int inc_times[$];
    logic prev_i = 1'b0, prev_d = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (inc_pulse) begin
            n_inc++;
            inc_times.push_back(cyc);
        end
        if (dec_pulse) n_dec++;
        if (inc_pulse && dec_pulse) overlap++;
        if ((inc_pulse && prev_i) || (dec_pulse && prev_d)) wide++;
        prev_i = inc_pulse;
        prev_d = dec_pulse;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; btn_inc = 1'b0; btn_dec = 1'b0;
        cycles(2);
        rst = 1'b0;
        cycles(1);
    endtask

    // Waits up to 30 cycles for the selected level to equal val. It returns
    // the number of cycles waited.
    task automatic wait_lvl(input bit dec, input bit val, output int n);
        n = 0;
        while (((dec ? dec_level : inc_level) != val) && n < 30) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n, base, base2, lv, idx, bad;
        rst = 1'b1; btn_inc = 1'b1; btn_dec = 1'b0;

        // Reset is held with btn_inc high, and all outputs stay low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_outputs", int'({inc_pulse, dec_pulse, inc_level, dec_level}), 0);
        end
        rst = 1'b0;
        base = n_inc;
        wait_lvl(1'b0, 1'b1, n);
        check("rst_lvl_latency", n, 8);
        check("rst_pulse_before", int'(inc_pulse), 0);
        cycles(1);
        check("rst_pulse", int'(inc_pulse), 1);
        cycles(1);
        check("rst_pulse_width", int'(inc_pulse), 0);
        rst = 1'b1;
        cycles(1);
        check("rst_mid_press_lvl", int'(inc_level), 0);
        do_reset();
        check("rst_pulse_count", n_inc - base, 1);

        // Glitch: 4 cycles high is shorter than 3 ticks.
        base = n_inc; lv = 0;
        btn_inc = 1'b1;
        cycles(4);
        btn_inc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lv |= int'(inc_level);
        end
        check("glitch_lvl", lv, 0);
        check("glitch_pulse", n_inc - base, 0);

        // Bounce: the button toggles every 3 cycles, then is held high.
        base = n_dec; lv = 0;
        for (int k = 0; k < 4; k++) begin
            btn_dec = (k % 2 == 0);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                lv |= int'(dec_level);
            end
        end
        btn_dec = 1'b1;
        wait_lvl(1'b1, 1'b1, n);
        check("bounce_no_early_lvl", lv, 0);
        check("bounce_latency_ok", int'(n >= 6 && n <= 7), 1);
        check("bounce_no_early_pulse", n_dec - base, 0);
        cycles(2);
        check("bounce_pulse", n_dec - base, 1);
        do_reset();

        // Simultaneous press, then release dec only, then release inc.
        base = n_inc; base2 = n_dec;
        btn_inc = 1'b1; btn_dec = 1'b1;
        cycles(40);
        check("sim_pulses", (n_inc - base) + (n_dec - base2), 0);
        check("sim_levels", int'({inc_level, dec_level}), 3);
        check("sim_state", int'(dut.state), 5);
        btn_dec = 1'b0;
        cycles(20);
        check("half_rel_pulses", (n_inc - base) + (n_dec - base2), 0);
        check("half_rel_state", int'(dut.state), 5);
        btn_inc = 1'b0;
        cycles(20);
        check("full_rel_state", int'(dut.state), 0);
        check("full_rel_pulses", (n_inc - base) + (n_dec - base2), 0);
        btn_inc = 1'b1;
        wait_lvl(1'b0, 1'b1, n);
        cycles(2);
        check("new_press_pulse", n_inc - base, 1);
        do_reset();

        // Hold btn_inc for 40 cycles.
        base = n_inc;
        idx = inc_times.size();
        btn_inc = 1'b1;
        cycles(40);
        btn_inc = 1'b0;
`ifdef AUTO_REPEAT_EN
        if (inc_times.size() >= idx + 3) begin
            check("rep_gap_first", inc_times[idx+1] - inc_times[idx], 8);
            check("rep_gap_rate", inc_times[idx+2] - inc_times[idx+1], 4);
        end else begin
            check("rep_pulse_count_min", inc_times.size() - idx, 3);
        end
        wait_lvl(1'b0, 1'b0, n);
        bad = 0;
        for (int i = idx + 2; i < inc_times.size(); i++)
            if (inc_times[i] - inc_times[i-1] != 4) bad++;
        check("rep_gaps_steady", bad, 0);
        base = n_inc;
        cycles(10);
        check("rep_stop_after_release", n_inc - base, 0);
`else
        wait_lvl(1'b0, 1'b0, n);
        cycles(5);
        check("hold_one_pulse", n_inc - base, 1);
`endif
        do_reset();

        // Cross-press: hold inc, then press dec 2 cycles later.
        base = n_inc; base2 = n_dec;
        btn_inc = 1'b1;
        cycles(2);
        btn_dec = 1'b1;
        cycles(20);
        check("cross_inc_pulses", n_inc - base, 1);
        check("cross_dec_pulses", n_dec - base2, 0);
        check("cross_levels", int'({inc_level, dec_level}), 3);
        check("cross_state", int'(dut.state), 5);
        do_reset();

        check("pulse_overlap", overlap, 0);
        check("pulse_width", wide, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
